fifo_uart_tx: RTL and testbench

//  Downstream drain stage for the synchronous fifo (d_w x 2**ad_w). Pops one word at a

---
 rtl/fifo_uart_pkg.sv | 16 +
 rtl/fifo_uart_tx_baud_gen.sv | 36 +++
 rtl/fifo_uart_tx.sv | 133 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared types and line levels for the fifo-draining UART transmitter.
package fifo_uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      LOAD  = 3'd2,
      START = 3'd3,
      DATA  = 3'd4,
      STOP  = 3'd5
   } state_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_baud_gen.sv
// Bit-period counter: counts 0..clks_per_bit-1 and flags the last cycle of each bit.
module baud_gen #(
   parameter int clks_per_bit = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = $clog2(clks_per_bit);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(clks_per_bit - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick = (cnt_q == LAST);

   // Next count: held at zero while cleared, wraps after the last cycle of a bit.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr || tick) begin
         cnt_d = '0;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the upstream fifo one word at a time and serializes each word as
// start bit, d_w data bits LSB first, stop bit.
//
//  state | meaning
//  IDLE  | line high, waiting for en && !empty
//  READ  | one-cycle fifo read strobe
//  LOAD  | fifo data_out valid, captured into the shift register
//  START | start bit on the line
//  DATA  | data bits, LSB first
//  STOP  | stop bit; then next word or back to IDLE
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int d_w          = 8,
   parameter int clks_per_bit = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic           empty,
   input  logic [d_w-1:0] data_in,
   output logic           read,
   output logic           tx,
   output logic           busy
);

   localparam int IDX_W = $clog2(d_w);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(d_w - 1);

   state_t           state_q, state_d;
   logic [d_w-1:0]   sh_q, sh_d;
   logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
   logic             read_q, read_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             baud_clr;
   logic             tick;

   // The bit counter sits at zero outside the serial states so START always
   // begins a full bit period.
   assign baud_clr = (state_q != START) && (state_q != DATA) && (state_q != STOP);

   baud_gen #(
      .clks_per_bit(clks_per_bit)
   ) u_baud_gen (
      .clk  (clk),
      .rst  (rst),
      .clr  (baud_clr),
      .tick (tick)
   );

   // Next-state, shift register and bit index.
   always_comb begin
      state_d   = state_q;
      sh_d      = sh_q;
      bit_idx_d = bit_idx_q;
      case (state_q)
         IDLE: begin
            if (en && !empty) begin
               state_d = READ;
            end
         end
         READ: begin
            state_d = LOAD;
         end
         LOAD: begin
            sh_d      = data_in;
            bit_idx_d = '0;
            state_d   = START;
         end
         START: begin
            if (tick) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (tick) begin
               sh_d = sh_q >> 1;
               if (bit_idx_q == LAST_IDX) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end
         end
         STOP: begin
            if (tick) begin
               state_d = (en && !empty) ? READ : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so the registered copies line up
   // with the state they belong to.
   always_comb begin
      read_d = (state_d == READ);
      busy_d = (state_d != IDLE);
      tx_d   = STOP_BIT;
      if (state_d == START) begin
         tx_d = START_BIT;
      end else if (state_d == DATA) begin
         tx_d = sh_d[0];
      end
   end

   // State, datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sh_q      <= '0;
         bit_idx_q <= '0;
         read_q    <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sh_q      <= sh_d;
         bit_idx_q <= bit_idx_d;
         read_q    <= read_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end

   assign read = read_q;
   assign tx   = tx_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx with a 16x8 fifo model upstream and a UART receiver
// scoreboard on the tx line.
module tb_fifo_uart_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       empty;
   logic [7:0] data_in;
   logic       read;
   logic       tx;
   logic       busy;

   logic       fifo_rst;
   logic       wr;
   logic [7:0] wr_data;
   logic [7:0] mem [16];
   logic [3:0] wp, rp;
   logic [4:0] cnt;
   logic       do_wr, do_rd;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int read_cnt = 0;
   int lost     = 0;
   logic [7:0] exp_q[$];
   int         starts[$];

   always #10 clk = ~clk;

   fifo_uart_tx #(.d_w(8), .clks_per_bit(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .empty   (empty),
      .data_in (data_in),
      .read    (read),
      .tx      (tx),
      .busy    (busy)
   );

   // Synchronous fifo with registered data_out (valid the cycle after read).
   assign empty = (cnt == 5'd0);
   assign do_wr = wr && (cnt != 5'd16);
   assign do_rd = read && (cnt != 5'd0);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_rst) begin
         wp <= '0; rp <= '0; cnt <= '0; data_in <= '0;
      end else begin
         if (do_wr) begin
            mem[wp] <= wr_data;
            wp      <= wp + 4'd1;
         end
         if (do_rd) begin
            data_in <= mem[rp];
            rp      <= rp + 4'd1;
         end
         cnt <= cnt + 5'(do_wr) - 5'(do_rd);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Receiver: every bit held 4 cycles, LSB first, stop high, bytes in order.
   int         pos = 0;
   bit         in_frame = 0;
   bit         stable;
   logic       cur;
   logic [7:0] rx;
   logic       read_prev = 1'b0;

   always @(posedge clk) begin
      #1;
      if (read === 1'b1) begin
         check("read_while_empty", empty, 0);
         check("read_double_pulse", read_prev, 0);
         read_cnt++;
      end
      read_prev = read;
      if (rst) begin
         if (in_frame) begin
            in_frame = 0;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            lost++;
         end
      end else begin
         if (!in_frame && tx === 1'b0) begin
            in_frame = 1;
            pos = 0;
            starts.push_back(cyc);
            check("busy_in_frame", busy, 1);
         end
         if (in_frame) begin
            if (pos % 4 == 0) begin
               cur = tx;
               stable = 1;
            end else if (tx !== cur) begin
               stable = 0;
            end
            if (pos % 4 == 0 && pos >= 4 && pos <= 32) rx[pos/4 - 1] = tx;
            if (pos % 4 == 3) check("bit_held_4_cycles", stable, 1);
            if (pos == 36) check("stop_bit", tx, 1);
            if (pos == 39) begin
               check("frame_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) check("rx_byte", rx, exp_q.pop_front());
               in_frame = 0;
            end
            pos++;
         end
      end
   end

   task automatic nxt();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input logic [7:0] w);
      wr = 1'b1;
      wr_data = w;
      exp_q.push_back(w);
      nxt();
      wr = 1'b0;
   endtask

   task automatic wait_busy(input string tag);
      int n = 0;
      while (busy !== 1'b1 && n < 50) begin
         nxt();
         n++;
      end
      check(tag, busy, 1);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0 || cnt != 5'd0) && n < 3000) begin
         nxt();
         n++;
      end
      check(tag, n < 3000, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog_timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, s0, l0, bc;
      rst = 1'b1; fifo_rst = 1'b1; en = 1'b1; wr = 1'b0; wr_data = '0;

      // 1: reset, empty fifo
      repeat (2) begin
         nxt();
         check("rst_tx", tx, 1);
         check("rst_read", read, 0);
         check("rst_busy", busy, 0);
      end
      rst = 1'b0; fifo_rst = 1'b0;
      repeat (3) begin
         nxt();
         check("post_rst_tx", tx, 1);
         check("post_rst_read", read, 0);
         check("post_rst_busy", busy, 0);
      end

      // 2: single word
      r0 = read_cnt;
      push(8'hA5);
      wait_busy("a5_busy_rise");
      bc = 0;
      while (busy === 1'b1 && bc < 200) begin
         bc++;
         nxt();
      end
      check("a5_busy_cycles", bc, 42);
      wait_idle("a5_done");
      check("a5_reads", read_cnt - r0, 1);
      check("a5_fifo_empty", empty, 1);

      // 3: back-to-back words
      r0 = read_cnt;
      s0 = starts.size();
      push(8'h01); push(8'h80); push(8'hFF);
      wait_idle("b2b_done");
      check("b2b_reads", read_cnt - r0, 3);
      check("b2b_frames", starts.size() - s0, 3);
      if (starts.size() - s0 == 3) begin
         check("b2b_spacing_1", starts[s0+1] - starts[s0], 42);
         check("b2b_spacing_2", starts[s0+2] - starts[s0+1], 42);
      end

      // 4: sixteen words
      r0 = read_cnt;
      for (int i = 0; i < 16; i++) push(8'(i * 37 + 5));
      wait_idle("fill_done");
      check("fill_reads", read_cnt - r0, 16);
      check("fill_fifo_empty", empty, 1);

      // 5: en dropped mid-frame
      r0 = read_cnt;
      push(8'h12); push(8'h34); push(8'h56);
      wait_busy("en_busy_rise");
      repeat (12) nxt();
      en = 1'b0;
      repeat (100) nxt();
      check("en0_reads", read_cnt - r0, 1);
      check("en0_tx_high", tx, 1);
      check("en0_busy", busy, 0);
      check("en0_fifo_count", cnt, 2);
      check("en0_pending", exp_q.size(), 2);
      en = 1'b1;
      wait_idle("en1_done");
      check("en1_reads", read_cnt - r0, 3);

      // 6: reset during data bit 3
      r0 = read_cnt;
      l0 = lost;
      push(8'h3C); push(8'h5A);
      wait_busy("rst_mid_busy_rise");
      repeat (19) nxt();
      rst = 1'b1;
      nxt();
      check("rst_mid_tx", tx, 1);
      check("rst_mid_busy", busy, 0);
      rst = 1'b0;
      wait_idle("rst_mid_done");
      check("rst_mid_lost", lost - l0, 1);
      check("rst_mid_reads", read_cnt - r0, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
